uart_frame_shifter: RTL and testbench

//  Parametrised successor to the plain UART shift register, shared by the TX and RX data paths of the APB-wrapped UART.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_bit_counter.sv | 34 +++
 rtl/uart_frame_shifter.sv | 96 +++++++++
 tb/tb_uart_frame_shifter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the frame shifter and the uart_tx/uart_rx blocks.
package uart_pkg;

    localparam int unsigned UART_MAX_W = 9;

    // A zero or oversize requested length selects the full register width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_w);
        return ((len == 0) || (len > max_w)) ? max_w : len;
    endfunction

endpackage

// File: rtl/uart_bit_counter.sv
// Frame bit counter: loads the frame length, counts accepted shifts down,
// and flags busy plus a one-cycle done pulse on the final bit.
module uart_bit_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             shift_acc,
    output logic             busy,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                cnt_q <= len;
            end else if (shift_acc && busy) begin
                cnt_q <= cnt_q - CNT_W'(1);
                done  <= (cnt_q == CNT_W'(1));
            end
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/uart_frame_shifter.sv
// Run-time length UART shift register shared by TX and RX paths:
// parallel load / serial out, serial in / parallel read, LSB- or MSB-first, live parity.
module uart_frame_shifter
    import uart_pkg::*;
#(
    parameter  int unsigned MAX_W = UART_MAX_W,
    localparam int unsigned CNT_W = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [MAX_W-1:0] parallel_in,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             cfg_msb_first,
    input  logic             cfg_odd,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [MAX_W-1:0] parallel_out,
    output logic             parity,
    output logic             busy,
    output logic             done
);

    logic [MAX_W-1:0] reg_q;
    logic [MAX_W-1:0] reg_d;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] mask_new;
    logic [MAX_W-1:0] top_bit;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_new;
    logic             msb_q;
    logic             odd_q;
    logic             shift_acc;

    assign len_new   = CNT_W'(clamp_len(32'(cfg_len), MAX_W));
    assign shift_acc = shift_en & busy & ~load;
    assign top_bit   = MAX_W'(1) << (len_q - CNT_W'(1));

    // Active-bit masks for the latched length and for the length being loaded.
    always_comb begin
        mask     = '0;
        mask_new = '0;
        for (int i = 0; i < MAX_W; i++) begin
            mask[i]     = (CNT_W'(i) < len_q);
            mask_new[i] = (CNT_W'(i) < len_new);
        end
    end

    // Bits above len_q are always zero, so a plain right shift never pulls in stale data.
    always_comb begin
        reg_d = reg_q;
        if (load) begin
            reg_d = parallel_in & mask_new;
        end else if (shift_acc) begin
            if (msb_q) begin
                reg_d = ((reg_q << 1) | MAX_W'(serial_in)) & mask;
            end else begin
                reg_d = ((reg_q >> 1) & mask) | (serial_in ? top_bit : '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
            len_q <= CNT_W'(MAX_W);
            msb_q <= 1'b0;
            odd_q <= 1'b0;
        end else begin
            reg_q <= reg_d;
            if (load) begin
                len_q <= len_new;
                msb_q <= cfg_msb_first;
                odd_q <= cfg_odd;
            end
        end
    end

    assign serial_out   = msb_q ? |(reg_q & top_bit) : reg_q[0];
    assign parallel_out = reg_q & mask;
    assign parity       = (^(reg_q & mask)) ^ odd_q;

    uart_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .len       (len_new),
        .shift_acc (shift_acc),
        .busy      (busy),
        .done      (done)
    );

endmodule

// File: tb/tb_uart_frame_shifter.sv
// Directed self-checking bench for uart_frame_shifter (MAX_W = 9).
module tb_uart_frame_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [8:0] parallel_in;
    logic [3:0] cfg_len;
    logic       cfg_msb_first;
    logic       cfg_odd;
    logic       shift_en;
    logic       serial_in;
    logic       serial_out;
    logic [8:0] parallel_out;
    logic       parity;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    uart_frame_shifter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .parallel_in   (parallel_in),
        .cfg_len       (cfg_len),
        .cfg_msb_first (cfg_msb_first),
        .cfg_odd       (cfg_odd),
        .shift_en      (shift_en),
        .serial_in     (serial_in),
        .serial_out    (serial_out),
        .parallel_out  (parallel_out),
        .parity        (parity),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input logic [8:0] w, input logic [3:0] len,
                              input logic m, input logic o);
        parallel_in   = w;
        cfg_len       = len;
        cfg_msb_first = m;
        cfg_odd       = o;
        load          = 1'b1;
        cyc();
        load          = 1'b0;
    endtask

    logic [7:0] tx_word;
    logic [6:0] rx_word;
    logic [2:0] gap_bits;
    logic [8:0] gap_exp [3];

    initial begin
        rst_n = 1'b0; load = 1'b0; parallel_in = '0; cfg_len = '0;
        cfg_msb_first = 1'b0; cfg_odd = 1'b0; shift_en = 1'b0; serial_in = 1'b0;
        repeat (2) cyc();
        check("rst_serial_out", 32'(serial_out), 0);
        check("rst_parallel_out", 32'(parallel_out), 0);
        check("rst_parity", 32'(parity), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        cyc();

        // Reset mid-frame after 3 of 8 bits
        load_frame(9'h0A5, 4'd8, 1'b0, 1'b0);
        check("t1_busy", 32'(busy), 1);
        shift_en = 1'b1;
        repeat (3) cyc();
        shift_en = 1'b0;
        check("t1_partial", 32'(parallel_out), 'h14);
        #2 rst_n = 1'b0;
        #1;
        check("t1_abort_reg", 32'(parallel_out), 0);
        check("t1_abort_busy", 32'(busy), 0);
        check("t1_abort_done", 32'(done), 0);
        check("t1_abort_sout", 32'(serial_out), 0);
        cyc();
        check("t1_no_done", 32'(done), 0);
        rst_n = 1'b1;
        cyc();

        // TX LSB-first 0xA5
        tx_word = 8'hA5;
        load_frame(9'h0A5, 4'd8, 1'b0, 1'b0);
        serial_in = 1'b0;
        shift_en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_bit%0d", i), 32'(serial_out), 32'(tx_word[i]));
            check($sformatf("t2_done_early%0d", i), 32'(done), 0);
            cyc();
        end
        check("t2_done", 32'(done), 1);
        check("t2_busy_fall", 32'(busy), 0);
        check("t2_reg_empty", 32'(parallel_out), 0);
        shift_en = 1'b0;
        cyc();
        check("t2_done_one_cycle", 32'(done), 0);

        // RX MSB-first, 7 bits -> 0x59
        rx_word = 7'b1011001;
        load_frame(9'h000, 4'd7, 1'b1, 1'b0);
        shift_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            serial_in = rx_word[6-i];
            cyc();
        end
        shift_en = 1'b0;
        check("t3_word", 32'(parallel_out), 'h59);
        check("t3_parity", 32'(parity), 0);
        check("t3_done", 32'(done), 1);
        check("t3_busy", 32'(busy), 0);
        cyc();

        // Strobes while idle are ignored
        shift_en  = 1'b1;
        serial_in = 1'b1;
        repeat (4) cyc();
        shift_en = 1'b0;
        check("t4_idle_hold", 32'(parallel_out), 'h59);
        check("t4_idle_busy", 32'(busy), 0);
        check("t4_idle_done", 32'(done), 0);

        // Sparse strobes, 3-bit LSB frame of 0b101
        gap_bits   = 3'b101;
        gap_exp[0] = 9'h006;
        gap_exp[1] = 9'h003;
        gap_exp[2] = 9'h005;
        load_frame(9'h005, 4'd3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            serial_in = gap_bits[k];
            shift_en  = 1'b1;
            cyc();
            shift_en  = 1'b0;
            check($sformatf("t4_shift%0d", k), 32'(parallel_out), 32'(gap_exp[k]));
            check($sformatf("t4_done%0d", k), 32'(done), (k == 2) ? 1 : 0);
            if (k < 2) begin
                repeat (15) cyc();
                check($sformatf("t4_gap_hold%0d", k), 32'(parallel_out), 32'(gap_exp[k]));
                check($sformatf("t4_gap_busy%0d", k), 32'(busy), 1);
            end
        end
        cyc();

        // cfg_len = 0 clamps to a 9-bit frame
        load_frame(9'h1FF, 4'd0, 1'b0, 1'b0);
        check("t5a_word", 32'(parallel_out), 'h1FF);
        check("t5a_parity", 32'(parity), 1);
        serial_in = 1'b0;
        shift_en  = 1'b1;
        repeat (8) cyc();
        check("t5a_busy8", 32'(busy), 1);
        check("t5a_done8", 32'(done), 0);
        cyc();
        shift_en = 1'b0;
        check("t5a_done9", 32'(done), 1);
        check("t5a_busy9", 32'(busy), 0);

        // cfg_len = 5 masks upper bits, odd parity
        load_frame(9'h1FF, 4'd5, 1'b0, 1'b1);
        check("t5b_word", 32'(parallel_out), 'h1F);
        check("t5b_parity", 32'(parity), 0);
        check("t5b_sout", 32'(serial_out), 1);

        // Load coincident with the final shift wins
        shift_en = 1'b1;
        repeat (4) cyc();
        check("t6_pre_word", 32'(parallel_out), 'h01);
        check("t6_pre_busy", 32'(busy), 1);
        parallel_in   = 9'h0C3;
        cfg_len       = 4'd8;
        cfg_msb_first = 1'b1;
        cfg_odd       = 1'b0;
        load          = 1'b1;
        cyc();
        load     = 1'b0;
        shift_en = 1'b0;
        check("t6_word", 32'(parallel_out), 'hC3);
        check("t6_busy", 32'(busy), 1);
        check("t6_done", 32'(done), 0);
        check("t6_sout", 32'(serial_out), 1);
        check("t6_parity", 32'(parity), 0);
        cyc();
        check("t6_done_later", 32'(done), 0);
        check("t6_busy_later", 32'(busy), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
